// File: rtl/clint_bus_arbiter_if.sv
// clint_bus_arbiter_if: two requester ports and the shared CLINT port
interface clint_bus_arbiter_if;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr;
    logic [3:0]  m0_wmask, m1_wmask;
    logic [31:0] m0_wdata, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        m0_err, m1_err;
    logic        c_valid;
    logic [31:0] c_addr;
    logic [3:0]  c_wmask;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic        c_ready;

    modport slave (
        input  m0_valid, m1_valid, m0_addr, m1_addr, m0_wmask, m1_wmask,
               m0_wdata, m1_wdata, c_rdata, c_ready,
        output m0_rdata, m1_rdata, m0_ready, m1_ready, m0_err, m1_err,
               c_valid, c_addr, c_wmask, c_wdata
    );

    modport master (
        output m0_valid, m1_valid, m0_addr, m1_addr, m0_wmask, m1_wmask,
               m0_wdata, m1_wdata, c_rdata, c_ready,
        input  m0_rdata, m1_rdata, m0_ready, m1_ready, m0_err, m1_err,
               c_valid, c_addr, c_wmask, c_wdata
    );
endinterface

// File: rtl/clint_bus_arbiter.sv
// clint_bus_arbiter: round-robin sharing of the CLINT port between two masters with timeout
module clint_bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    clint_bus_arbiter_if.slave   bus,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_n;
    logic        gnt, last, err, req, win, timeout;
    logic [7:0]  cnt;
    logic [31:0] rdata0, rdata1;

    assign req     = bus.m0_valid | bus.m1_valid;
    assign win     = (bus.m0_valid & bus.m1_valid) ? ~last : bus.m1_valid;
    assign timeout = cnt == 8'(TIMEOUT - 1);

    // next state, owner-muxed CLINT request and owner-steered response pulses
    always_comb begin
        state_n      = state == IDLE ? (req ? BUSY : IDLE) :
                       state == BUSY ? ((bus.c_ready | timeout) ? RESP : BUSY) : IDLE;
        bus.c_valid  = state == BUSY;
        bus.c_addr   = gnt ? bus.m1_addr : bus.m0_addr;
        bus.c_wmask  = gnt ? bus.m1_wmask : bus.m0_wmask;
        bus.c_wdata  = gnt ? bus.m1_wdata : bus.m0_wdata;
        bus.m0_ready = state == RESP && !gnt;
        bus.m1_ready = state == RESP && gnt;
        bus.m0_err   = bus.m0_ready & err;
        bus.m1_err   = bus.m1_ready & err;
        bus.m0_rdata = rdata0;
        bus.m1_rdata = rdata1;
        busy         = state != IDLE;
    end

    // state, grant bookkeeping, timeout counter and response capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            gnt    <= 1'b0;
            last   <= 1'b1;
            cnt    <= 8'd0;
            err    <= 1'b0;
            rdata0 <= 32'd0;
            rdata1 <= 32'd0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                gnt  <= win;
                last <= win;
                cnt  <= 8'd0;
            end
            if (state == BUSY && state_n == BUSY)
                cnt <= cnt + 8'd1;
            if (state == BUSY && state_n == RESP) begin
                err <= ~bus.c_ready;
                if (gnt)
                    rdata1 <= bus.c_ready ? bus.c_rdata : 32'd0;
                else
                    rdata0 <= bus.c_ready ? bus.c_rdata : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_clint_bus_arbiter.sv
// tb_clint_bus_arbiter: randomized transaction-level check of the CLINT arbiter
module tb_clint_bus_arbiter;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        busy;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] cmem [5];
    logic [31:0] rmem [5];
    logic [31:0] exp_rd0 = 32'd0;
    logic [31:0] exp_rd1 = 32'd0;
    logic        ref_last = 1'b1;
    int          cm_n = 0;
    int          cm_l = 0;
    logic        cm_pcv = 1'b0;
    logic [31:0] cm_a = 32'd0;
    logic [31:0] cm_wd = 32'd0;
    logic [3:0]  cm_wm = 4'd0;
    logic [31:0] addr_tab [7] = '{32'h1100_0000, 32'h1100_4000, 32'h1100_4004, 32'h1100_bff8,
                                  32'h1100_bffc, 32'h1100_0008, 32'h1100_0010};

    clint_bus_arbiter_if bus ();

    clint_bus_arbiter #(.TIMEOUT(T)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic int idx(input logic [31:0] a);
        case (a)
            32'h1100_0000: return 0;
            32'h1100_4000: return 1;
            32'h1100_4004: return 2;
            32'h1100_bff8: return 3;
            32'h1100_bffc: return 4;
            default:       return -1;
        endcase
    endfunction

    // CLINT answer delay in cycles counted from c_valid rising (1 = first BUSY cycle); 0 = never
    function automatic int lat(input logic [31:0] a);
        case (a)
            32'h1100_0000: return 3;
            32'h1100_4000: return 2;
            32'h1100_4004: return 4;
            32'h1100_bff8: return 2;
            32'h1100_bffc: return T;
            32'h1100_0010: return T + 1;
            default:       return 0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] wm, input logic [31:0] wd);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // CLINT model: answers after the address's latency, returns the pre-write value
    initial begin
        bus.c_ready = 1'b0;
        bus.c_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.c_ready = 1'b0;
            if (bus.c_valid && !cm_pcv) begin
                cm_n  = 1;
                cm_a  = bus.c_addr;
                cm_wm = bus.c_wmask;
                cm_wd = bus.c_wdata;
                cm_l  = lat(cm_a);
            end else if (cm_n != 0) cm_n++;
            if (cm_n != 0 && cm_n == cm_l) begin
                bus.c_ready = 1'b1;
                if (idx(cm_a) >= 0) begin
                    bus.c_rdata = cmem[idx(cm_a)];
                    if (bus.c_valid) cmem[idx(cm_a)] = merge(cmem[idx(cm_a)], cm_wm, cm_wd);
                end else bus.c_rdata = 32'hDEAD_BEEF;
                cm_n = 0;
            end
            if (cm_n > 400) cm_n = 0;
            cm_pcv = bus.c_valid;
        end
    end

    task automatic do_round(input logic r0, input logic r1,
                            input logic [31:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                            input logic [31:0] a1, input logic [3:0] w1, input logic [31:0] d1);
        logic        o [2];
        logic        hit [2];
        int          st [2];
        int          rs [2];
        logic [31:0] ea [2];
        logic [3:0]  ew [2];
        logic [31:0] ed [2];
        logic [31:0] erd [2];
        int          ns, endk, l, dur;
        logic        cv, bz, rd0, rd1, er0, er1;
        ns   = (r0 && r1) ? 2 : 1;
        o[0] = (r0 && r1) ? !ref_last : r1;
        o[1] = !o[0];
        ref_last = o[ns-1];
        st[0] = 0;
        for (int i = 0; i < ns; i++) begin
            ea[i]  = o[i] ? a1 : a0;
            ew[i]  = o[i] ? w1 : w0;
            ed[i]  = o[i] ? d1 : d0;
            l      = lat(ea[i]);
            hit[i] = l != 0 && l <= T;
            dur    = hit[i] ? l : T;
            if (i == 1) st[1] = rs[0] + 1;
            rs[i]  = st[i] + dur + 1;
            erd[i] = 32'd0;
            if (hit[i] && idx(ea[i]) >= 0) begin
                erd[i] = rmem[idx(ea[i])];
                rmem[idx(ea[i])] = merge(rmem[idx(ea[i])], ew[i], ed[i]);
            end
        end
        endk = rs[ns-1] + 1;
        bus.m0_valid = r0; bus.m0_addr = a0; bus.m0_wmask = w0; bus.m0_wdata = d0;
        bus.m1_valid = r1; bus.m1_addr = a1; bus.m1_wmask = w1; bus.m1_wdata = d1;
        for (int k = 0; k <= endk; k++) begin
            cv = 0; bz = 0; rd0 = 0; rd1 = 0; er0 = 0; er1 = 0;
            for (int i = 0; i < ns; i++) begin
                if (k > st[i] && k < rs[i]) cv = 1;
                if (k > st[i] && k <= rs[i]) bz = 1;
                if (k == rs[i] && o[i]) begin rd1 = 1; er1 = !hit[i]; exp_rd1 = erd[i]; end
                if (k == rs[i] && !o[i]) begin rd0 = 1; er0 = !hit[i]; exp_rd0 = erd[i]; end
                if (k == st[i] + 1) begin
                    check("c_addr", bus.c_addr, ea[i]);
                    check("c_wmask", 32'(bus.c_wmask), 32'(ew[i]));
                    check("c_wdata", bus.c_wdata, ed[i]);
                end
            end
            check("c_valid", 32'(bus.c_valid), 32'(cv));
            check("busy", 32'(busy), 32'(bz));
            check("m0_ready", 32'(bus.m0_ready), 32'(rd0));
            check("m1_ready", 32'(bus.m1_ready), 32'(rd1));
            if (rd0) check("m0_err", 32'(bus.m0_err), 32'(er0));
            if (rd1) check("m1_err", 32'(bus.m1_err), 32'(er1));
            check("m0_rdata", bus.m0_rdata, exp_rd0);
            check("m1_rdata", bus.m1_rdata, exp_rd1);
            if (rd0) bus.m0_valid = 1'b0;
            if (rd1) bus.m1_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [1:0] pat;
        for (int i = 0; i < 5; i++) begin
            cmem[i] = $urandom;
            rmem[i] = cmem[i];
        end
        cmem[1] = 32'd0;           rmem[1] = 32'd0;
        cmem[3] = 32'h1234_5678;   rmem[3] = 32'h1234_5678;
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h1100_bff8; bus.m0_wmask = 4'd0; bus.m0_wdata = 32'd0;
        bus.m1_valid = 1'b0; bus.m1_addr = 32'd0; bus.m1_wmask = 4'd0; bus.m1_wdata = 32'd0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_c_valid", 32'(bus.c_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_m0_ready", 32'(bus.m0_ready), 32'd0);
            check("rst_m1_ready", 32'(bus.m1_ready), 32'd0);
            check("rst_m0_err", 32'(bus.m0_err), 32'd0);
            check("rst_m1_err", 32'(bus.m1_err), 32'd0);
            check("rst_m0_rdata", bus.m0_rdata, 32'd0);
            check("rst_m1_rdata", bus.m1_rdata, 32'd0);
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("first_c_valid", 32'(bus.c_valid), 32'd1);
        check("first_c_addr", bus.c_addr, 32'h1100_bff8);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        bus.m0_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_c_valid", 32'(bus.c_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_m0_ready", 32'(bus.m0_ready), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_no_pulse", 32'(bus.m0_ready), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        ref_last = 1'b1;
        do_round(1, 1, 32'h1100_bff8, 4'd0, 32'd0, 32'h1100_4004, 4'd0, 32'd0);
        do_round(1, 1, 32'h1100_0000, 4'd0, 32'd0, 32'h1100_bffc, 4'd0, 32'd0);
        do_round(1, 0, 32'h1100_bff8, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0);
        do_round(0, 1, 32'd0, 4'd0, 32'd0, 32'h1100_4000, 4'b0001, 32'h0000_00AB);
        do_round(1, 0, 32'h1100_4000, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0);
        do_round(1, 1, 32'h1100_0008, 4'd0, 32'd0, 32'h1100_4000, 4'd0, 32'd0);
        do_round(1, 1, 32'h1100_0010, 4'hF, 32'h5555_AAAA, 32'h1100_0008, 4'd0, 32'd0);
        for (int r = 0; r < 80; r++) begin
            pat = 2'($urandom_range(1, 3));
            do_round(pat[0], pat[1],
                     addr_tab[$urandom_range(0, 6)], 4'($urandom_range(0, 15)), $urandom,
                     addr_tab[$urandom_range(0, 6)], 4'($urandom_range(0, 15)), $urandom);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
